// File: rtl/counter_dec_4w_ctrl.sv
// counter_dec_4w_ctrl: run controller for the 4-digit BCD counter chain.
// Loads a preset, then issues plus/minus step strobes every TICK_DIV cycles
// until the terminal value is reached (zero for countdown, preset for count-up).
// Supports pause/resume (prescaler phase kept) and abort.
//
// Optional build macro: COUNTER_DEC_CTRL_AUTORELOAD_EN
//   defined   -> DONE is a one-cycle pulse followed by an automatic reload
//                with the retained preset/direction (periodic timer).
//   undefined -> DONE is held until i_start or i_stop.
//
// All outputs are registered. A step strobe is decided one edge ahead, so it
// is high in the RUN cycle in which the prescaler sits at TICK_DIV-1. The
// counter can only change after one of our strobes and TICK_DIV >= 2, so the
// terminal flags seen one cycle early equal those of the strobe cycle.
module counter_dec_4w_ctrl #(
    parameter int TICK_DIV = 1000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_pause,
    input  logic            i_stop,
    input  logic            i_dir,
    input  logic [3:0][3:0] i_preset,
    input  logic [3:0][3:0] i_value,
    input  logic            i_zero,
    output logic [3:0][3:0] o_count,
    output logic            o_load,
    output logic            o_plus,
    output logic            o_minus,
    output logic            o_busy,
    output logic            o_paused,
    output logic            o_done
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_inc;
    logic [3:0][3:0] preset_q;
    logic            dir_q;
    logic            terminal;

    // Terminal condition of the current run and the wrapped prescaler increment
    assign terminal  = dir_q ? (i_value == preset_q) : i_zero;
    assign presc_inc = (presc == PRESC_MAX) ? '0 : presc + 1'b1;

    // Run FSM with registered strobes and status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            preset_q <= '0;
            dir_q    <= 1'b0;
            o_count  <= '0;
            o_load   <= 1'b0;
            o_plus   <= 1'b0;
            o_minus  <= 1'b0;
            o_busy   <= 1'b0;
            o_paused <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_load  <= 1'b0;
            o_plus  <= 1'b0;
            o_minus <= 1'b0;
            if (i_stop && state != S_IDLE) begin
                // abort: counter contents are left as they are
                state    <= S_IDLE;
                presc    <= '0;
                o_busy   <= 1'b0;
                o_paused <= 1'b0;
                o_done   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            dir_q    <= i_dir;
                            preset_q <= i_preset;
                            o_count  <= i_dir ? '0 : i_preset;
                            o_load   <= 1'b1;
                            o_busy   <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        presc <= '0;
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        if (terminal) begin
                            state  <= S_DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            // the cycle carrying the pause pulse still counts as RUN
                            presc <= presc_inc;
                            if (i_pause) begin
                                state    <= S_PAUSE;
                                o_paused <= 1'b1;
                            end else if (presc_inc == PRESC_MAX) begin
                                o_plus  <= dir_q;
                                o_minus <= ~dir_q;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (i_pause) begin
                            state    <= S_RUN;
                            o_paused <= 1'b0;
                            if (presc == PRESC_MAX) begin
                                o_plus  <= dir_q;
                                o_minus <= ~dir_q;
                            end
                        end
                    end
                    S_DONE: begin
                        if (i_start) begin
                            dir_q    <= i_dir;
                            preset_q <= i_preset;
                            o_count  <= i_dir ? '0 : i_preset;
                            o_load   <= 1'b1;
                            o_busy   <= 1'b1;
                            o_done   <= 1'b0;
                            state    <= S_LOAD;
                        end
`ifdef COUNTER_DEC_CTRL_AUTORELOAD_EN
                        else begin
                            o_count <= dir_q ? '0 : preset_q;
                            o_load  <= 1'b1;
                            o_busy  <= 1'b1;
                            o_done  <= 1'b0;
                            state   <= S_LOAD;
                        end
`endif
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
